// File: rtl/puf_ro_pkg.sv
// Shared types and default sizing for the ring-oscillator PUF comparator.
package puf_ro_pkg;

  localparam int N_RO_DEF       = 8;
  localparam int CNT_W_DEF      = 16;
  localparam int WIN_W_DEF      = 16;
  localparam int SETTLE_CYC_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_COMPARE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/puf_ro_edge_cnt.sv
// One measurement channel: 3-flop synchroniser, rising-edge detect and a
// saturating edge counter with synchronous clear and count-enable.
module puf_ro_edge_cnt
  import puf_ro_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             ro_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [2:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rise;

  // NOTE: non-blocking assignments make each stage take the previous stage's
  // old value, so this really is three flops and not one.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], ro_i};
    end
  end

  // sync_q[0] may be metastable; only the two settled stages feed the detector
  assign rise = sync_q[1] & ~sync_q[2];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && rise && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/puf_ro_cmp.sv
// Ring-oscillator PUF measurement core: enables a challenge-selected pair,
// counts edges over a window and reports A > B. Optional macro PUF_RO_CNT_OUT_EN.
module puf_ro_cmp
  import puf_ro_pkg::*;
#(
  parameter  int N_RO       = N_RO_DEF,
  parameter  int CNT_W      = CNT_W_DEF,
  parameter  int WIN_W      = WIN_W_DEF,
  parameter  int SETTLE_CYC = SETTLE_CYC_DEF,
  localparam int SEL_W      = $clog2(N_RO)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_RO-1:0]  i_ro,
  output logic [N_RO-1:0]  o_ro_en,
  input  logic             i_start,
  input  logic [SEL_W-1:0] i_sel_a,
  input  logic [SEL_W-1:0] i_sel_b,
  input  logic [WIN_W-1:0] i_win,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_resp,
  output logic             o_tie,
  output logic             o_err
`ifdef PUF_RO_CNT_OUT_EN
  ,
  output logic [CNT_W-1:0] o_cnt_a,
  output logic [CNT_W-1:0] o_cnt_b
`endif
);

  state_e           state_q, state_d;
  logic [WIN_W-1:0] cyc_q, cyc_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [SEL_W-1:0] sel_a_q, sel_a_d;
  logic [SEL_W-1:0] sel_b_q, sel_b_d;
  logic [N_RO-1:0]  ro_en_q, ro_en_d;
  logic             resp_q, resp_d;
  logic             tie_q, tie_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_a, cnt_b;
  logic             challenge_ok;

`ifdef PUF_RO_CNT_OUT_EN
  logic [CNT_W-1:0] res_cnt_a_q, res_cnt_a_d;
  logic [CNT_W-1:0] res_cnt_b_q, res_cnt_b_d;
`endif

  assign challenge_ok = (i_sel_a != i_sel_b) &&
                        (int'(i_sel_a) < N_RO) && (int'(i_sel_b) < N_RO);

  // NOTE: every next-state variable is given its hold value first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    win_d   = win_q;
    sel_a_d = sel_a_q;
    sel_b_d = sel_b_q;
    ro_en_d = ro_en_q;
    resp_d  = resp_q;
    tie_d   = tie_q;
    err_d   = err_q;
`ifdef PUF_RO_CNT_OUT_EN
    res_cnt_a_d = res_cnt_a_q;
    res_cnt_b_d = res_cnt_b_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          sel_a_d = i_sel_a;
          sel_b_d = i_sel_b;
          win_d   = i_win;
          if (!challenge_ok || (i_win == '0)) begin
            // short-circuit runs never touch the bank and report zero counts
            state_d = ST_DONE;
            err_d   = !challenge_ok;
            tie_d   = challenge_ok;
            resp_d  = 1'b0;
`ifdef PUF_RO_CNT_OUT_EN
            res_cnt_a_d = '0;
            res_cnt_b_d = '0;
`endif
          end else begin
            state_d          = ST_SETTLE;
            cyc_d            = WIN_W'(SETTLE_CYC - 1);
            ro_en_d          = '0;
            ro_en_d[i_sel_a] = 1'b1;
            ro_en_d[i_sel_b] = 1'b1;
          end
        end
      end
      ST_SETTLE: begin
        if (cyc_q == '0) begin
          state_d = ST_MEASURE;
          cyc_d   = win_q - WIN_W'(1);
        end else begin
          cyc_d = cyc_q - WIN_W'(1);
        end
      end
      ST_MEASURE: begin
        if (cyc_q == '0) begin
          state_d = ST_COMPARE;
          ro_en_d = '0;
        end else begin
          cyc_d = cyc_q - WIN_W'(1);
        end
      end
      ST_COMPARE: begin
        state_d = ST_DONE;
        resp_d  = (cnt_a > cnt_b);
        tie_d   = (cnt_a == cnt_b);
        err_d   = 1'b0;
`ifdef PUF_RO_CNT_OUT_EN
        res_cnt_a_d = cnt_a;
        res_cnt_b_d = cnt_b;
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Enables live in a flop so reset pulls them low without waiting for a clock.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      win_q   <= '0;
      sel_a_q <= '0;
      sel_b_q <= '0;
      ro_en_q <= '0;
      resp_q  <= 1'b0;
      tie_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      win_q   <= win_d;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
      ro_en_q <= ro_en_d;
      resp_q  <= resp_d;
      tie_q   <= tie_d;
      err_q   <= err_d;
    end
  end

`ifdef PUF_RO_CNT_OUT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      res_cnt_a_q <= '0;
      res_cnt_b_q <= '0;
    end else begin
      res_cnt_a_q <= res_cnt_a_d;
      res_cnt_b_q <= res_cnt_b_d;
    end
  end

  assign o_cnt_a = res_cnt_a_q;
  assign o_cnt_b = res_cnt_b_q;
`endif

  puf_ro_edge_cnt #(.CNT_W(CNT_W)) u_cnt_a (
    .clk_i   (i_clk),
    .rst_n_i (i_rst_n),
    .ro_i    (i_ro[sel_a_q]),
    .clr_i   (state_q == ST_SETTLE),
    .en_i    (state_q == ST_MEASURE),
    .cnt_o   (cnt_a)
  );

  puf_ro_edge_cnt #(.CNT_W(CNT_W)) u_cnt_b (
    .clk_i   (i_clk),
    .rst_n_i (i_rst_n),
    .ro_i    (i_ro[sel_b_q]),
    .clr_i   (state_q == ST_SETTLE),
    .en_i    (state_q == ST_MEASURE),
    .cnt_o   (cnt_b)
  );

  assign o_ro_en = ro_en_q;
  assign o_busy  = (state_q == ST_SETTLE) || (state_q == ST_MEASURE) ||
                   (state_q == ST_COMPARE);
  assign o_done  = (state_q == ST_DONE);
  assign o_resp  = resp_q;
  assign o_tie   = tie_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_puf_ro_cmp.sv
// Directed bench for puf_ro_cmp: modelled oscillator bank plus a per-cycle
// outcome model derived from periods, window length and challenge legality.
module tb_puf_ro_cmp;

  localparam int N_RO   = 8;
  localparam int SETTLE = 4;
  localparam int BUDGET = 3000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  osc = '0;
  logic [7:0]  ro;
  logic [7:0]  ro_en;
  logic        start = 1'b0;
  logic [2:0]  sel_a = '0, sel_b = '0;
  logic [15:0] win = '0;
  logic        busy, done, resp, tie, err;
`ifdef PUF_RO_CNT_OUT_EN
  logic [15:0] cnt_a_o, cnt_b_o;
`endif

  int tests = 0;
  int fails = 0;

  // oscillator periods in ns, 0 = stuck low
  int per [8] = '{40, 60, 50, 50, 0, 0, 0, 0};

  // expectation for the run in flight
  bit   active = 1'b0;
  int   cyc;
  int   exp_lat, exp_win, exp_ca, exp_cb;
  bit   exp_long, exp_err, exp_tie, exp_resp;
  logic [7:0] exp_mask;
  bit   last_resp = 1'b0, last_tie = 1'b0, last_err = 1'b0;

  always #5 clk = ~clk;

  // bank: disabled oscillators are held low; edges never land on a clk edge
  initial begin #2; forever #20 osc[0] = ~osc[0]; end
  initial begin #3; forever #30 osc[1] = ~osc[1]; end
  initial begin #1; forever begin #25 osc[2] = ~osc[2]; osc[3] = ~osc[3]; end end
  assign ro = osc & ro_en;

  puf_ro_cmp dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_ro    (ro),
    .o_ro_en (ro_en),
    .i_start (start),
    .i_sel_a (sel_a),
    .i_sel_b (sel_b),
    .i_win   (win),
    .o_busy  (busy),
    .o_done  (done),
    .o_resp  (resp),
    .o_tie   (tie),
    .o_err   (err)
`ifdef PUF_RO_CNT_OUT_EN
    ,
    .o_cnt_a (cnt_a_o),
    .o_cnt_b (cnt_b_o)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_near(input string name, input int act, input int exp);
    tests++;
    if (act < exp - 1 || act > exp + 1) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d +/-1", name, act, exp);
    end
  endtask

  // per-cycle compare against the outcome model
  always @(negedge clk) begin
    if (active) begin
      cyc++;
      if (cyc < exp_lat) begin
        check("done_early", done, 1'b0);
        check("busy_run", busy, exp_long);
        check("ro_en_run", ro_en, (exp_long && cyc <= SETTLE + exp_win) ? exp_mask : 8'h00);
      end else begin
        check("done_at_lat", done, 1'b1);
        check("busy_at_done", busy, 1'b0);
        check("ro_en_at_done", ro_en, 8'h00);
        check("resp", resp, exp_resp);
        check("tie", tie, exp_tie);
        check("err", err, exp_err);
`ifdef PUF_RO_CNT_OUT_EN
        if (exp_long) begin
          check_near("cnt_a", int'(cnt_a_o), exp_ca);
          check_near("cnt_b", int'(cnt_b_o), exp_cb);
        end else begin
          check("cnt_a_zero", cnt_a_o, 16'd0);
          check("cnt_b_zero", cnt_b_o, 16'd0);
        end
`endif
        last_resp = exp_resp;
        last_tie  = exp_tie;
        last_err  = exp_err;
        active    = 1'b0;
      end
    end else begin
      check("idle_done", done, 1'b0);
      check("idle_busy", busy, 1'b0);
      check("idle_ro_en", ro_en, 8'h00);
      check("held_resp", resp, last_resp);
      check("held_tie", tie, last_tie);
      check("held_err", err, last_err);
    end
  end

  // One measurement. ign_at: cycle to pulse a stray start; rst_at: cycle to reset.
  task automatic run(input int a, input int b, input int w,
                     input int ign_at, input int rst_at, output int lat);
    int  n;
    bit  stop;
    @(negedge clk);
    sel_a = 3'(a);
    sel_b = 3'(b);
    win   = 16'(w);
    start = 1'b1;
    @(posedge clk);
    exp_err  = (a == b) || (a >= N_RO) || (b >= N_RO);
    exp_long = !exp_err && (w != 0);
    exp_win  = w;
    exp_lat  = exp_long ? (1 + SETTLE + w + 1) : 1;
    exp_mask = exp_long ? 8'((1 << a) | (1 << b)) : 8'h00;
    exp_ca   = (exp_long && per[a] != 0) ? (w * 10) / per[a] : 0;
    exp_cb   = (exp_long && per[b] != 0) ? (w * 10) / per[b] : 0;
    exp_resp = exp_long && (exp_ca > exp_cb);
    exp_tie  = !exp_err && (exp_ca == exp_cb);
    cyc      = 0;
    active   = 1'b1;
    n    = 0;
    lat  = -1;
    stop = 1'b0;
    while (!stop && n < BUDGET) begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
      if (done && lat < 0) lat = n;
      if (n == ign_at) begin
        start = 1'b1;
        sel_a = 3'd5;
        sel_b = 3'd5;
        win   = 16'd0;
      end
      if (n == ign_at + 1) start = 1'b0;
      if (n == rst_at) begin
        #2;
        active    = 1'b0;
        last_resp = 1'b0;
        last_tie  = 1'b0;
        last_err  = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("rst_ro_en", ro_en, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_resp", resp, 1'b0);
        check("rst_done", done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stop  = 1'b1;
      end
      if (!active) stop = 1'b1;
    end
    check("run_bounded", (n < BUDGET), 1'b1);
  endtask

  initial begin
    int lat;
    #20;
    check("reset_ro_en", ro_en, 8'h00);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_resp", resp, 1'b0);
    check("reset_tie", tie, 1'b0);
    check("reset_err", err, 1'b0);
    #3 rst_n = 1'b1;

    // A (40 ns) faster than B (60 ns): 30 vs 20 edges
    fork
      run(0, 1, 120, 0, 0, lat);
      begin
        repeat (62) @(negedge clk);
        check("pin_ro_en_pair", ro_en, 8'b0000_0011);
      end
    join
    check("pin_lat_126", lat, 126);
    check("pin_resp_fast_a", resp, 1'b1);
    check("pin_tie_fast_a", tie, 1'b0);

    // reset mid-MEASURE, then a fresh run
    run(0, 1, 120, 0, 60, lat);
    run(0, 1, 120, 0, 0, lat);
    check("pin_resp_after_rst", resp, 1'b1);

    // swapped pair with a stray start mid-run
    run(1, 0, 120, 30, 0, lat);
    check("pin_resp_swapped", resp, 1'b0);
    check("pin_tie_swapped", tie, 1'b0);

    // equal, phase-aligned oscillators
    run(2, 3, 100, 0, 0, lat);
    check("pin_tie_equal", tie, 1'b1);
    check("pin_resp_equal", resp, 1'b0);

    // illegal challenge
    run(5, 5, 120, 0, 0, lat);
    check("pin_lat_illegal", lat, 1);
    check("pin_err_illegal", err, 1'b1);

    // zero window
    run(0, 1, 0, 0, 0, lat);
    check("pin_lat_win0", lat, 1);
    check("pin_tie_win0", tie, 1'b1);
    check("pin_err_win0", err, 1'b0);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
